calc_controller: RTL and testbench
==================================

# calc_controller

Sequencing controller for the calculator datapath. It accepts a one-cycle start request with two operands and a 2-bit operation code, then runs the selected operation: single-cycle add/sub, or multi-cycle repeated ×2 / ÷2 shifting. It registers the result and flags and signals completion with a one-cycle done pulse. It sits between the user-input capture logic and the display/result path.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥4)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- start  in  1  request pulse; sampled only in IDLE
- op_sel  in  2  00 add, 01 sub, 10 mul2, 11 div2
- operand_a  in  WIDTH  first operand, unsigned
- operand_b  in  WIDTH  second operand (add/sub), or shift count in bits [2:0] (mul2/div2)
- busy  out  1  high while in EXEC
- done  out  1  one-cycle pulse in DONE
- result  out  WIDTH  registered result; held until the next accepted start completes
- carry_out  out  1  add: carry out; sub: borrow (a<b); 0 for shifts
- ovf  out  1  sticky; a 1 bit shifted out (mul2 MSB, div2 LSB); 0 for add/sub

## Operation
- States: IDLE, EXEC, DONE; encoding is 2-bit binary.
- IDLE, start=1: capture a, b, op_sel and cnt=b[2:0] into internal registers. Clear the internal ovf accumulator and go to EXEC. If start=0, stay in IDLE.
- EXEC, add: result←(a+b) mod 2^WIDTH; carry_out←carry; ovf←0; go to DONE.
- EXEC, sub: result←(a−b) mod 2^WIDTH; carry_out←(a<b); ovf←0; go to DONE.
- EXEC, mul2/div2 with cnt=0: result←a; carry_out←0; ovf←0; go to DONE after 1 EXEC cycle.
- EXEC, mul2/div2 with cnt>0: on each edge, shift the working register one bit (logical left or logical right, zero-fill) and decrement cnt. OR the bit shifted out into ovf. On the edge where cnt goes 1→0, write result, carry_out=0 and ovf, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE unconditionally.
- start in EXEC or DONE is ignored. It is not queued.
- Operand and op_sel inputs are don't-care outside the IDLE start edge.
- result, carry_out and ovf change only on the edge that enters DONE. They hold their values otherwise.

## Timing
- Reset (async, immediate): state=IDLE; busy=0, done=0, result=0, carry_out=0, ovf=0; internal registers and cnt=0.
- Start sampled at edge k → busy=1 from edge k.
- Add/sub/zero-count shift: DONE entered at edge k+1, so done is high between k+1 and k+2.
- Shift with count n (1..7): DONE entered at edge k+n.
- Start-to-done latency is max(1,n) edges. Idle-to-idle turnaround is max(1,n)+1 edges.
- Back-to-back: the earliest next accepted start is the edge after DONE is left (state IDLE).
- Reset asserted mid-EXEC aborts the operation with no done pulse. The first start after rst deasserts behaves normally.
- busy and done are never high simultaneously.

## Structure
- Shared package calc_pkg holds:
  - op codes OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL2=2'b10, OP_DIV2=2'b11;
  - state encodings ST_IDLE, ST_EXEC, ST_DONE;
  - the shift-count field width constant (3).
- One sub-module, calc_alu_step. It is purely combinational and takes the working value, b, and op. It returns the next value, carry/borrow, and the shifted-out bit for a single step.
- The FSM, count register and flag accumulation live in calc_controller.

## Test plan
- add, a=200, b=100 → result=44, carry_out=1, ovf=0; done high during the cycle after edge k+1; busy high for 1 cycle.
- sub, a=5, b=7 → result=254, carry_out=1. Then sub a=7, b=5 → result=2, carry_out=0.
- mul2, a=0x41, b=3 → result=0x08, ovf=1; done at edge k+3; busy high for 3 cycles.
- div2, a=0x80, b=0 → result=0x80, ovf=0 after 1 EXEC cycle. Then div2 a=0x03, b=1 → result=0x01, ovf=1.
- start re-pulsed on every cycle during mul2 a=1, b=7 → only the first is accepted; result=0x80, ovf=0; exactly one done pulse.
- rst asserted on the 2nd EXEC cycle of a b=5 shift → outputs 0 immediately; no done pulse. A subsequent add 1+1 → result=2.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared op codes, FSM state encoding and shift-count width for the calculator controller.
package calc_pkg;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL2 = 2'b10;
    localparam logic [1:0] OP_DIV2 = 2'b11;
    localparam int CNT_W = 3;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;
endpackage

// File: rtl/calc_alu_step.sv
// calc_alu_step: one combinational step of the calculator datapath.
// Ports: value/b/op in; next = stepped value, cry = add carry or sub borrow,
// out_bit = bit lost by a x2 (MSB) or /2 (LSB) shift.
module calc_alu_step
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] next,
    output logic             cry,
    output logic             out_bit
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    // The extra top bit of the widened subtraction is set exactly when value < b.
    assign sum  = {1'b0, value} + {1'b0, b};
    assign diff = {1'b0, value} - {1'b0, b};
    always_comb begin
        next    = op == OP_ADD  ? sum[WIDTH-1:0] :
                  op == OP_SUB  ? diff[WIDTH-1:0] :
                  op == OP_MUL2 ? {value[WIDTH-2:0], 1'b0} : {1'b0, value[WIDTH-1:1]};
        cry     = op == OP_ADD ? sum[WIDTH] : op == OP_SUB ? diff[WIDTH] : 1'b0;
        out_bit = op == OP_MUL2 ? value[WIDTH-1] : op == OP_DIV2 ? value[0] : 1'b0;
    end
endmodule

// File: rtl/calc_controller.sv
// calc_controller: IDLE/EXEC/DONE sequencer running add/sub in one cycle and x2 or /2 shifts over cnt cycles.
// Ports: clk, rst (async high); start/op_sel/operand_a/operand_b request; busy (EXEC), done (one-cycle pulse),
// result/carry_out/ovf registered and updated only on the edge entering DONE.
module calc_controller
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op_sel,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             ovf
);
    state_t             state, state_nx;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   b_q;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   cnt;
    logic               acc;
    logic [WIDTH-1:0]   step_val;
    logic               step_cry;
    logic               step_out;
    logic               is_shift;
    logic               shifting;
    logic               finish;

    calc_alu_step #(.WIDTH(WIDTH)) u_step (
        .value  (work),
        .b      (b_q),
        .op     (op_q),
        .next   (step_val),
        .cry    (step_cry),
        .out_bit(step_out)
    );

    assign is_shift = op_q[1];
    assign shifting = is_shift && cnt != '0;
    // Add/sub and zero-count shifts finish in one EXEC cycle; real shifts finish as cnt goes 1->0.
    assign finish   = !shifting || cnt == CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            ST_IDLE: state_nx = start ? ST_EXEC : ST_IDLE;
            ST_EXEC: begin
                busy     = 1'b1;
                state_nx = finish ? ST_DONE : ST_EXEC;
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work      <= '0;
            b_q       <= '0;
            op_q      <= '0;
            cnt       <= '0;
            acc       <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            work <= operand_a;
            b_q  <= operand_b;
            op_q <= op_sel;
            cnt  <= operand_b[CNT_W-1:0];
            acc  <= 1'b0;
        end else if (state == ST_EXEC) begin
            if (shifting) begin
                work <= step_val;
                cnt  <= cnt - CNT_W'(1);
                acc  <= acc | step_out;
            end
            if (finish) begin
                result    <= (is_shift && !shifting) ? work : step_val;
                carry_out <= !is_shift && step_cry;
                ovf       <= shifting && (acc || step_out);
            end
        end
    end
endmodule

// File: tb/tb_calc_controller.sv
// tb_calc_controller: randomized self-checking bench for calc_controller against an arithmetic reference model.
module tb_calc_controller;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op_sel = 2'b00;
    logic [7:0] operand_a = 8'd0;
    logic [7:0] operand_b = 8'd0;
    logic       busy, done, carry_out, ovf;
    logic [7:0] result;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_r = 8'd0;

    calc_controller #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_sel   (op_sel),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry_out(carry_out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic; shifts by n are multiply/divide by 2**n, lost bits decide ovf.
    function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c, output logic o, output int lat);
        int ia = int'(a);
        int ib = int'(b);
        int n  = ib % 8;
        int p  = 2 ** n;
        r = 8'd0; c = 1'b0; o = 1'b0; lat = 1;
        case (op)
            OP_ADD: begin r = 8'((ia + ib) % 256); c = (ia + ib) > 255; end
            OP_SUB: begin r = 8'((ia - ib + 256) % 256); c = ia < ib; end
            OP_MUL2: begin r = 8'((ia * p) % 256); o = (ia * p) / 256 != 0; lat = n == 0 ? 1 : n; end
            default: begin r = 8'(ia / p); o = (ia % p) != 0; lat = n == 0 ? 1 : n; end
        endcase
    endfunction

    // Issues one request and measures: edges to done, busy cycles, done pulses, busy&done overlap,
    // result changing before done, and busy after the DONE edge. hold keeps start high throughout.
    task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input bit hold,
                          output int lat, output int busy_n, output int done_n, output int overlap,
                          output int early, output int post_busy);
        @(negedge clk);
        op_sel = op; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) begin
            start = 1'b0;
            operand_a = 8'($urandom); operand_b = 8'($urandom); op_sel = 2'($urandom);
        end
        lat = 0; busy_n = 0; done_n = 0; overlap = 0; early = 0;
        while (!done && lat < 20) begin
            busy_n += int'(busy);
            if (result !== model_r) early = 1;
            @(posedge clk); #1;
            lat++;
        end
        if (done) done_n = 1;
        overlap = int'(busy && done);
        @(posedge clk); #1;
        start = 1'b0;
        post_busy = int'(busy);
        if (done) done_n++;
    endtask

    task automatic check_op(input string name, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                            input bit hold, input logic [7:0] want_r, input logic want_c, input logic want_o,
                            input int want_lat);
        int lat, bn, dn, ov, ea, pb;
        run_op(op, a, b, hold, lat, bn, dn, ov, ea, pb);
        checks++;
        if ({result, carry_out, ovf} !== {want_r, want_c, want_o}) begin
            errors++;
            $display("FAIL %s value: got r=%h c=%b o=%b, expected r=%h c=%b o=%b",
                     name, result, carry_out, ovf, want_r, want_c, want_o);
        end
        checks++;
        if (lat != want_lat || bn != want_lat || dn != 1) begin
            errors++;
            $display("FAIL %s timing: got lat=%0d busy=%0d dones=%0d, expected lat=%0d busy=%0d dones=1",
                     name, lat, bn, dn, want_lat, want_lat);
        end
        checks++;
        if (ov != 0 || ea != 0 || pb != 0) begin
            errors++;
            $display("FAIL %s protocol: got overlap=%0d early_change=%0d busy_after=%0d, expected all 0",
                     name, ov, ea, pb);
        end
        model_r = want_r;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy, done, result, carry_out, ovf} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b r=%h c=%b o=%b, expected all 0",
                     busy, done, result, carry_out, ovf);
        end
        @(negedge clk); rst = 1'b0;
        model_r = 8'd0;
    endtask

    task automatic test_add();
        check_op("add_200_100", OP_ADD, 8'd200, 8'd100, 0, 8'd44, 1'b1, 1'b0, 1);
    endtask

    task automatic test_sub();
        check_op("sub_5_7", OP_SUB, 8'd5, 8'd7, 0, 8'd254, 1'b1, 1'b0, 1);
        check_op("sub_7_5", OP_SUB, 8'd7, 8'd5, 0, 8'd2, 1'b0, 1'b0, 1);
    endtask

    task automatic test_mul2();
        check_op("mul2_41_3", OP_MUL2, 8'h41, 8'd3, 0, 8'h08, 1'b0, 1'b1, 3);
    endtask

    task automatic test_div2();
        check_op("div2_80_0", OP_DIV2, 8'h80, 8'd0, 0, 8'h80, 1'b0, 1'b0, 1);
        check_op("div2_03_1", OP_DIV2, 8'h03, 8'd1, 0, 8'h01, 1'b0, 1'b1, 1);
    endtask

    task automatic test_start_ignored();
        check_op("mul2_restart", OP_MUL2, 8'h01, 8'd7, 1, 8'h80, 1'b0, 1'b0, 7);
    endtask

    task automatic test_reset_mid_exec();
        int seen = 0;
        check_op("pre_reset_add", OP_ADD, 8'd100, 8'd50, 0, 8'd150, 1'b0, 1'b0, 1);
        @(negedge clk);
        op_sel = OP_MUL2; operand_a = 8'h5A; operand_b = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, carry_out, ovf} !== 12'd0) begin
            errors++;
            $display("FAIL reset_mid_exec: got busy=%b done=%b r=%h c=%b o=%b, expected all 0",
                     busy, done, result, carry_out, ovf);
        end
        @(negedge clk); rst = 1'b0;
        model_r = 8'd0;
        repeat (8) begin
            @(posedge clk); #1;
            seen += int'(done);
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_abort_done: got %0d done pulses, expected 0", seen);
        end
        check_op("post_reset_add", OP_ADD, 8'd1, 8'd1, 0, 8'd2, 1'b0, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        logic c, o;
        int lat;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op = 2'($urandom_range(0, 3));
            logic [7:0] a = 8'($urandom);
            logic [7:0] b = 8'($urandom);
            model(op, a, b, r, c, o, lat);
            check_op($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), op, a, b, 0, r, c, o, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul2();
        test_div2();
        test_start_ignored();
        test_reset_mid_exec();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
